buffer_run_ctrl: RTL and testbench

- Sequences one run of the delay Buffer unit: latches the delay amount, drives the unit's running and amount inputs, and frames input-accept and output-valid windows for a programmed sample count.
- Guarantees at least one running-low cycle between runs so the unit's internal FIFO is cleared.
- Sits between the accelerator's run-control logic and a Buffer instance. Upstream data producers use in_en; downstream consumers use out_valid.

---
 rtl/buffer_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_buffer_run_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_run_ctrl.sv
// buffer_run_ctrl
// Sequences one run of a delay Buffer unit. An accepted start latches the
// delay amount and the run length. The controller then holds the Buffer's
// running input high for length+amount+1 cycles and frames the input-accept
// window (in_en) and the delayed-output window (out_valid). After each run
// there is a one-cycle DONE state with running low, so the Buffer's internal
// FIFO is cleared before the next run begins.
//
// Ports
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   start     : run request, honoured only in IDLE or DONE
//   abort     : synchronous cancel; has priority over start and over completion
//   amount_i  : delay amount, latched on an accepted start
//   length_i  : number of input samples, latched on an accepted start
//   running   : drives the Buffer running input
//   amount_o  : drives the Buffer amount input; stable for the whole run
//   in_en     : the Buffer input sample is consumed this cycle
//   out_valid : the Buffer output is a valid delayed sample this cycle
//   busy      : high while a run is in progress
//   done      : one-cycle pulse when a run completes normally
module buffer_run_ctrl #(
  parameter int DELAY_W = 7,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] amount_i,
  input  logic [LEN_W-1:0]   length_i,
  output logic               running,
  output logic [DELAY_W-1:0] amount_o,
  output logic               in_en,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  // One extra bit over the wider field, so amount+length can never wrap.
  localparam int CNT_W = ((LEN_W > DELAY_W) ? LEN_W : DELAY_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [DELAY_W-1:0] amt_r, amt_s;

  // The last run cycle index is amount+len. It is computed for the current
  // configuration (to end the run) and for the next one (to decode outputs).
  logic [CNT_W-1:0]   last_cur_s;
  logic [CNT_W-1:0]   amt_nxt_s, len_nxt_s, last_nxt_s, first_out_nxt_s;
  logic               running_s, in_en_s, out_valid_s, done_s;

  assign last_cur_s      = CNT_W'(amt_r) + CNT_W'(len_r);
  assign amt_nxt_s       = CNT_W'(amt_s);
  assign len_nxt_s       = CNT_W'(len_s);
  assign last_nxt_s      = amt_nxt_s + len_nxt_s;
  assign first_out_nxt_s = amt_nxt_s + CNT_W'(1);

  // Next state, next counter and next latched configuration.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    amt_s   = amt_r;
    case (state_r)
      IDLE, DONE: begin
        if (abort) begin
          state_s = IDLE;
          cnt_s   = CNT_W'(0);
        end else if (start) begin
          amt_s = amount_i;
          len_s = length_i;
          cnt_s = CNT_W'(0);
          if (length_i != LEN_W'(0)) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_W'(0);
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          cnt_s   = CNT_W'(0);
        end else if (cnt_r == last_cur_s) begin
          state_s = DONE;
          cnt_s   = CNT_W'(0);
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_W'(0);
      end
    endcase
  end

  // Output values for the cycle that follows, decoded from the next state and counter.
  always_comb begin
    running_s   = 1'b0;
    in_en_s     = 1'b0;
    out_valid_s = 1'b0;
    done_s      = 1'b0;
    if (state_s == RUN) begin
      running_s   = 1'b1;
      in_en_s     = (cnt_s < len_nxt_s);
      out_valid_s = (cnt_s >= first_out_nxt_s) && (cnt_s <= last_nxt_s);
    end else if (state_s == DONE) begin
      done_s = 1'b1;
    end else begin
      running_s = 1'b0;
    end
  end

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_W'(0);
      len_r     <= LEN_W'(0);
      amt_r     <= DELAY_W'(0);
      running   <= 1'b0;
      in_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      len_r     <= len_s;
      amt_r     <= amt_s;
      running   <= running_s;
      in_en     <= in_en_s;
      out_valid <= out_valid_s;
      busy      <= running_s;
      done      <= done_s;
    end
  end

  assign amount_o = amt_r;

endmodule

// File: tb/tb_buffer_run_ctrl.sv
`timescale 1ns/1ps
module tb_buffer_run_ctrl;

  localparam int DELAY_W = 7;
  localparam int LEN_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [DELAY_W-1:0] amount_i = '0;
  logic [LEN_W-1:0]   length_i = '0;
  logic               running, in_en, out_valid, busy, done;
  logic [DELAY_W-1:0] amount_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_amt = 0;

  buffer_run_ctrl #(.DELAY_W(DELAY_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .amount_i(amount_i), .length_i(length_i),
    .running(running), .amount_o(amount_o), .in_en(in_en),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".running"},   32'(running),   32'd0);
    check({tag, ".in_en"},     32'(in_en),     32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".amount_o"},  32'(amount_o),  32'(exp_amt));
  endtask

  // Present a start for one edge; the following cycle is the first running
  // cycle, or the DONE cycle when the length is zero.
  task automatic start_run(input int a, input int len);
    start    = 1'b1;
    amount_i = DELAY_W'(a);
    length_i = LEN_W'(len);
    step();
    start    = 1'b0;
    exp_amt  = a;
    amount_i = DELAY_W'($urandom);
    length_i = LEN_W'($urandom);
  endtask

  // Walk a full run from its first cycle, checking the windows against the
  // rules and feeding an ideal Buffer model (latency amount+1) with random
  // data. Ends sitting in the DONE cycle with start low.
  task automatic check_run(input int a, input int len, input bit noise);
    logic [15:0] pipe[$];
    logic [15:0] acc[$];
    logic [15:0] din, bout, want;
    bit bvalid;
    int nvalid;
    nvalid = 0;
    bout = '0;
    if (len != 0) begin
      for (int c = 0; c <= a + len; c++) begin
        check("run.running",   32'(running),   32'd1);
        check("run.busy",      32'(busy),      32'd1);
        check("run.done",      32'(done),      32'd0);
        check("run.in_en",     32'(in_en),     32'(c < len));
        check("run.out_valid", 32'(out_valid), 32'((c >= a + 1) && (c <= a + len)));
        check("run.amount_o",  32'(amount_o),  32'(a));
        din = 16'($urandom);
        pipe.push_back(din);
        if (c < len) acc.push_back(din);
        bvalid = 1'b0;
        if (pipe.size() > a + 1) begin
          bout   = pipe.pop_front();
          bvalid = 1'b1;
        end
        if (out_valid === 1'b1) begin
          nvalid++;
          check("buf.present", 32'(bvalid), 32'd1);
          want = (acc.size() > 0) ? acc.pop_front() : 16'hxxxx;
          check("buf.order", 32'(bout), 32'(want));
        end
        if (noise) begin
          start    = 1'($urandom);
          amount_i = DELAY_W'($urandom);
          length_i = LEN_W'($urandom);
        end
        step();
      end
      start = 1'b0;
      check("run.valid_count", 32'(nvalid), 32'(len));
    end
    check("done.done",      32'(done),      32'd1);
    check("done.running",   32'(running),   32'd0);
    check("done.busy",      32'(busy),      32'd0);
    check("done.in_en",     32'(in_en),     32'd0);
    check("done.out_valid", 32'(out_valid), 32'd0);
    check("done.amount_o",  32'(amount_o),  32'(a));
  endtask

  initial begin
    #5_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, len;
    // Reset state
    step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // amount 3, length 5: nine running cycles, then done
    start_run(3, 5);
    check_run(3, 5, 1'b0);
    step();
    check_idle("after_3_5");

    // amount 0: one-cycle latency; start/config noise during the run is ignored
    start_run(0, 4);
    check_run(0, 4, 1'b1);
    step();
    check_idle("after_0_4");

    // zero length goes straight to DONE, then back-to-back start from DONE
    start_run(9, 0);
    check_run(9, 0, 1'b0);
    start_run(1, 2);
    check_run(1, 2, 1'b0);
    step();
    check_idle("after_1_2");

    // abort at run cycle 2 of amount 4, length 6
    start_run(4, 6);
    for (int c = 0; c <= 2; c++) begin
      check("abort.running", 32'(running), 32'd1);
      check("abort.in_en",   32'(in_en),   32'd1);
      if (c == 2) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check_idle("abort_next");
    step();
    check_idle("abort_no_done");
    start_run(2, 2);
    check_run(2, 2, 1'b0);

    // abort beats start in DONE; the current done pulse was already out
    start    = 1'b1;
    abort    = 1'b1;
    amount_i = DELAY_W'(5);
    length_i = LEN_W'(3);
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_in_done");
    step();
    check_idle("abort_in_done2");

    // asynchronous reset in the middle of a run
    start_run(3, 5);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_amt = 0;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("after_async_reset");
    step();
    check_idle("after_async_reset2");

    // randomized runs, some back-to-back from DONE, some with an idle gap
    for (int i = 0; i < 10; i++) begin
      a   = int'($urandom_range(0, 20));
      len = int'($urandom_range(0, 12));
      start_run(a, len);
      check_run(a, len, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check_idle("rand_gap");
      end
    end
    step();
    check_idle("rand_end");

    // largest configuration: 65663 running cycles without counter wrap
    start_run(127, 65535);
    check_run(127, 65535, 1'b0);
    step();
    check_idle("after_max");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
